ras_ctrl: RTL and testbench

Pointer/sequencing controller for the dual-write-port return-address-stack RAM (RAS RAM with checkpoint copy).
- Maintains a speculative top-of-stack (fetch-side push/pop) and an architectural top-of-stack (commit-side push/pop).
- Drives the RAM read port, write port 0 (speculative push) and write port 1 (architectural push).
- Sequences misprediction recovery, including the RAM's one-cycle checkpoint restore.
- Sits between the fetch-stage branch predictor and the commit/recovery logic.

---
 rtl/ras_ctrl_pkg.sv | 19 +
 rtl/ras_ctrl_if.sv | 30 +++
 rtl/ras_ctrl_ptr.sv | 61 ++++++
 rtl/ras_ctrl.sv | 137 +++++++++++++
 tb/tb_ras_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ras_ctrl_pkg.sv
// Shared types for the return-address-stack controller: FSM state and the
// top-of-stack/count pair for the default configuration.
package ras_ctrl_pkg;

    localparam int unsigned RAS_DEPTH = 16;
    localparam int unsigned RAS_INDEX = 4;
    localparam int unsigned RAS_WIDTH = 8;

    typedef enum logic [0:0] {
        RAS_RUN     = 1'b0,
        RAS_RESTORE = 1'b1
    } ras_state_e;

    typedef struct packed {
        logic [RAS_INDEX-1:0] tos;
        logic [RAS_INDEX:0]   cnt;
    } ras_ptr_t;

endpackage

// File: rtl/ras_ctrl_if.sv
// RAM-side bus of the RAS controller: read port, two write ports and the
// checkpoint-restore flag. master = controller, slave = RAS RAM.
interface ras_ctrl_if
    import ras_ctrl_pkg::*;
#(
    parameter int unsigned INDEX = RAS_INDEX,
    parameter int unsigned WIDTH = RAS_WIDTH
);
    logic [INDEX-1:0] ram_addr0_o;
    logic [WIDTH-1:0] ram_data0_i;
    logic [INDEX-1:0] ram_addr0wr_o;
    logic [WIDTH-1:0] ram_data0wr_o;
    logic             ram_we0_o;
    logic [INDEX-1:0] ram_addr1wr_o;
    logic [WIDTH-1:0] ram_data1wr_o;
    logic             ram_we1_o;
    logic             ram_recover_o;

    modport master (
        output ram_addr0_o, ram_addr0wr_o, ram_data0wr_o, ram_we0_o,
        output ram_addr1wr_o, ram_data1wr_o, ram_we1_o, ram_recover_o,
        input  ram_data0_i
    );

    modport slave (
        input  ram_addr0_o, ram_addr0wr_o, ram_data0wr_o, ram_we0_o,
        input  ram_addr1wr_o, ram_data1wr_o, ram_we1_o, ram_recover_o,
        output ram_data0_i
    );
endinterface

// File: rtl/ras_ctrl_ptr.sv
// Top-of-stack / saturating-count update unit; one instance per stack view.
module ras_ptr
    import ras_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    parameter int unsigned INDEX = RAS_INDEX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             load_i,
    input  logic [INDEX-1:0] load_tos_i,
    input  logic [INDEX:0]   load_cnt_i,
    output logic [INDEX-1:0] tos_o,
    output logic [INDEX:0]   cnt_o,
    output logic             we_c,
    output logic [INDEX-1:0] waddr_c
);
    localparam logic [INDEX:0] CNT_FULL = (INDEX+1)'(DEPTH);

    logic [INDEX-1:0] tos_q, tos_d;
    logic [INDEX:0]   cnt_q, cnt_d;

    // Next pointer/count and write target; push+pop replaces the top entry
    always_comb begin
        tos_d   = tos_q;
        cnt_d   = cnt_q;
        we_c    = 1'b0;
        waddr_c = tos_q + INDEX'(1);
        if (load_i) begin
            tos_d = load_tos_i;
            cnt_d = load_cnt_i;
        end else if (push_i && pop_i) begin
            we_c    = 1'b1;
            waddr_c = tos_q;
        end else if (push_i) begin
            we_c  = 1'b1;
            tos_d = tos_q + INDEX'(1);
            if (cnt_q != CNT_FULL) cnt_d = cnt_q + (INDEX+1)'(1);
        end else if (pop_i && (cnt_q != '0)) begin
            tos_d = tos_q - INDEX'(1);
            cnt_d = cnt_q - (INDEX+1)'(1);
        end
    end

    // State register; empty stack points at DEPTH-1 so first push lands on 0
    always_ff @(posedge clk) begin
        if (!reset) begin
            tos_q <= INDEX'(DEPTH - 1);
            cnt_q <= '0;
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
        end
    end

    assign tos_o = tos_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack pointer/sequencing controller: speculative and
// architectural TOS tracking plus one-cycle checkpoint restore on recovery.
// Optional build macro RAS_CTRL_STATS_EN adds overflow/underflow/recover
// statistics outputs.
module ras_ctrl
    import ras_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    parameter int unsigned INDEX = RAS_INDEX,
    parameter int unsigned WIDTH = RAS_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spec_push_i,
    input  logic             spec_pop_i,
    input  logic [WIDTH-1:0] spec_addr_i,
    input  logic             arch_push_i,
    input  logic             arch_pop_i,
    input  logic [WIDTH-1:0] arch_addr_i,
    input  logic             recover_i,
    output logic             spec_ready_o,
    output logic             arch_ready_o,
    output logic [WIDTH-1:0] pred_addr_o,
    output logic             pred_valid_o,
`ifdef RAS_CTRL_STATS_EN
    output logic [31:0]      stat_overflow_o,
    output logic [31:0]      stat_underflow_o,
    output logic [31:0]      stat_recover_o,
`endif
    ras_ctrl_if.master       ram
);
    ras_state_e       state_q;
    logic             ram_recover_q;
    logic             in_run;
    logic             in_restore;
    logic             spec_push, spec_pop, arch_push, arch_pop;
    logic [INDEX-1:0] spec_tos, arch_tos;
    logic [INDEX:0]   spec_cnt, arch_cnt;

    assign in_run       = (state_q == RAS_RUN);
    assign in_restore   = (state_q == RAS_RESTORE);
    assign spec_ready_o = in_run && !recover_i;
    assign arch_ready_o = in_run;
    assign spec_push    = spec_push_i && spec_ready_o;
    assign spec_pop     = spec_pop_i  && spec_ready_o;
    assign arch_push    = arch_push_i && arch_ready_o;
    assign arch_pop     = arch_pop_i  && arch_ready_o;

    // Recovery FSM: RUN -> RESTORE for exactly one cycle; recover_i in RESTORE is ignored
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RAS_RUN;
            ram_recover_q <= 1'b0;
        end else begin
            case (state_q)
                RAS_RUN: begin
                    if (recover_i) begin
                        state_q       <= RAS_RESTORE;
                        ram_recover_q <= 1'b1;
                    end
                end
                RAS_RESTORE: begin
                    state_q       <= RAS_RUN;
                    ram_recover_q <= 1'b0;
                end
                default: begin
                    state_q       <= RAS_RUN;
                    ram_recover_q <= 1'b0;
                end
            endcase
        end
    end

    ras_ptr #(.DEPTH(DEPTH), .INDEX(INDEX)) u_spec_ptr (
        .clk        (clk),
        .reset      (reset),
        .push_i     (spec_push),
        .pop_i      (spec_pop),
        .load_i     (in_restore),
        .load_tos_i (arch_tos),
        .load_cnt_i (arch_cnt),
        .tos_o      (spec_tos),
        .cnt_o      (spec_cnt),
        .we_c       (ram.ram_we0_o),
        .waddr_c    (ram.ram_addr0wr_o)
    );

    ras_ptr #(.DEPTH(DEPTH), .INDEX(INDEX)) u_arch_ptr (
        .clk        (clk),
        .reset      (reset),
        .push_i     (arch_push),
        .pop_i      (arch_pop),
        .load_i     (1'b0),
        .load_tos_i ('0),
        .load_cnt_i ('0),
        .tos_o      (arch_tos),
        .cnt_o      (arch_cnt),
        .we_c       (ram.ram_we1_o),
        .waddr_c    (ram.ram_addr1wr_o)
    );

    assign ram.ram_addr0_o   = spec_tos;
    assign ram.ram_data0wr_o = spec_addr_i;
    assign ram.ram_data1wr_o = arch_addr_i;
    assign ram.ram_recover_o = ram_recover_q;
    assign pred_addr_o       = ram.ram_data0_i;
    assign pred_valid_o      = (spec_cnt != '0);

`ifdef RAS_CTRL_STATS_EN
    localparam logic [INDEX:0] CNT_FULL = (INDEX+1)'(DEPTH);

    logic [31:0] stat_ovf_q, stat_unf_q, stat_rec_q;
    logic        ovf_evt, unf_evt, rec_evt;

    assign ovf_evt = spec_push && !spec_pop && (spec_cnt == CNT_FULL);
    assign unf_evt = spec_pop && !spec_push && (spec_cnt == '0);
    assign rec_evt = in_run && recover_i;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_ovf_q <= '0;
            stat_unf_q <= '0;
            stat_rec_q <= '0;
        end else begin
            if (ovf_evt && (stat_ovf_q != '1)) stat_ovf_q <= stat_ovf_q + 32'd1;
            if (unf_evt && (stat_unf_q != '1)) stat_unf_q <= stat_unf_q + 32'd1;
            if (rec_evt && (stat_rec_q != '1)) stat_rec_q <= stat_rec_q + 32'd1;
        end
    end

    assign stat_overflow_o  = stat_ovf_q;
    assign stat_underflow_o = stat_unf_q;
    assign stat_recover_o   = stat_rec_q;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl with a RAS RAM model (main + checkpoint copy),
// a reference pointer model and a write-port scoreboard.
module tb_ras_ctrl;
    import ras_ctrl_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned INDEX = 4;
    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic             port;
        logic [INDEX-1:0] addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             spec_push_i, spec_pop_i, arch_push_i, arch_pop_i, recover_i;
    logic [WIDTH-1:0] spec_addr_i, arch_addr_i;
    logic             spec_ready_o, arch_ready_o, pred_valid_o;
    logic [WIDTH-1:0] pred_addr_o;

    ras_ctrl_if #(.INDEX(INDEX), .WIDTH(WIDTH)) ram_bus ();

    ras_ctrl #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .spec_push_i  (spec_push_i),
        .spec_pop_i   (spec_pop_i),
        .spec_addr_i  (spec_addr_i),
        .arch_push_i  (arch_push_i),
        .arch_pop_i   (arch_pop_i),
        .arch_addr_i  (arch_addr_i),
        .recover_i    (recover_i),
        .spec_ready_o (spec_ready_o),
        .arch_ready_o (arch_ready_o),
        .pred_addr_o  (pred_addr_o),
        .pred_valid_o (pred_valid_o),
        .ram          (ram_bus)
    );

    always #5 clk = ~clk;

    // RAS RAM model: port-1 writes mirror into the checkpoint, recover copies it back
    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] ckpt [DEPTH];
    assign ram_bus.ram_data0_i = mem[ram_bus.ram_addr0_o];
    always @(posedge clk) begin
        if (ram_bus.ram_recover_o) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= ckpt[i];
        end else begin
            if (ram_bus.ram_we0_o) mem[ram_bus.ram_addr0wr_o] <= ram_bus.ram_data0wr_o;
            if (ram_bus.ram_we1_o) begin
                mem[ram_bus.ram_addr1wr_o]  <= ram_bus.ram_data1wr_o;
                ckpt[ram_bus.ram_addr1wr_o] <= ram_bus.ram_data1wr_o;
            end
        end
    end

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    wr_t        exp_q[$];
    ras_ptr_t   m_spec, m_arch;
    ras_state_e m_state;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ras_ptr_t ptr_upd(input ras_ptr_t p, input logic push, input logic pop);
        ras_ptr_t n = p;
        if (push && !pop) begin
            n.tos = p.tos + INDEX'(1);
            if (p.cnt != (INDEX+1)'(DEPTH)) n.cnt = p.cnt + (INDEX+1)'(1);
        end else if (pop && !push && (p.cnt != '0)) begin
            n.tos = p.tos - INDEX'(1);
            n.cnt = p.cnt - (INDEX+1)'(1);
        end
        return n;
    endfunction

    task automatic model_reset();
        m_spec.tos = INDEX'(DEPTH - 1);
        m_spec.cnt = '0;
        m_arch     = m_spec;
        m_state    = RAS_RUN;
        exp_q.delete();
    endtask

    task automatic observe(input logic port, input logic [INDEX-1:0] addr, input logic [WIDTH-1:0] data);
        wr_t o, e;
        o = {port, addr, data};
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check(port ? "wr_port1" : "wr_port0", 32'(o), 32'(e));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        spec_push_i = 1'b0; spec_pop_i = 1'b0; spec_addr_i = '0;
        arch_push_i = 1'b0; arch_pop_i = 1'b0; arch_addr_i = '0;
        recover_i = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        reset = 1'b1;
    endtask

    // One clock: drive, predict writes, check at negedge, advance model at posedge
    task automatic cycle(input logic sp_push, input logic sp_pop, input logic [WIDTH-1:0] sp_addr,
                         input logic ar_push, input logic ar_pop, input logic [WIDTH-1:0] ar_addr,
                         input logic rec, input logic rst_n = 1'b1);
        logic e_sr, e_ar;
        wr_t  w;
        spec_push_i = sp_push; spec_pop_i = sp_pop; spec_addr_i = sp_addr;
        arch_push_i = ar_push; arch_pop_i = ar_pop; arch_addr_i = ar_addr;
        recover_i = rec; reset = rst_n;
        e_sr = (m_state == RAS_RUN) && !rec;
        e_ar = (m_state == RAS_RUN);
        if (e_sr && sp_push) begin
            w.port = 1'b0; w.data = sp_addr;
            w.addr = sp_pop ? m_spec.tos : m_spec.tos + INDEX'(1);
            exp_q.push_back(w);
        end
        if (e_ar && ar_push) begin
            w.port = 1'b1; w.data = ar_addr;
            w.addr = ar_pop ? m_arch.tos : m_arch.tos + INDEX'(1);
            exp_q.push_back(w);
        end
        @(negedge clk);
        check("spec_ready", 32'(spec_ready_o), 32'(e_sr));
        check("arch_ready", 32'(arch_ready_o), 32'(e_ar));
        check("ram_recover", 32'(ram_bus.ram_recover_o), 32'(m_state == RAS_RESTORE));
        check("rd_addr", 32'(ram_bus.ram_addr0_o), 32'(m_spec.tos));
        check("pred_valid", 32'(pred_valid_o), 32'(m_spec.cnt != '0));
        check("pred_addr", 32'(pred_addr_o), 32'(mem[m_spec.tos]));
        if (ram_bus.ram_we0_o) observe(1'b0, ram_bus.ram_addr0wr_o, ram_bus.ram_data0wr_o);
        if (ram_bus.ram_we1_o) observe(1'b1, ram_bus.ram_addr1wr_o, ram_bus.ram_data1wr_o);
        check("wr_missing", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (m_state == RAS_RESTORE) begin
            m_spec  = m_arch;
            m_state = RAS_RUN;
        end else begin
            m_arch = ptr_upd(m_arch, ar_push, ar_pop);
            if (rec) m_state = RAS_RESTORE;
            else     m_spec  = ptr_upd(m_spec, sp_push, sp_pop);
        end
        #1;
    endtask

    task automatic idle(input logic rec = 1'b0, input logic rst_n = 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, rec, rst_n);
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_spec_ready", 32'(spec_ready_o), 32'd1);
        check("rst_arch_ready", 32'(arch_ready_o), 32'd1);
        check("rst_pred_valid", 32'(pred_valid_o), 32'd0);
        check("rst_ram_recover", 32'(ram_bus.ram_recover_o), 32'd0);
        check("rst_rd_addr", 32'(ram_bus.ram_addr0_o), 32'd15);
        check("rst_we", 32'({ram_bus.ram_we0_o, ram_bus.ram_we1_o}), 32'd0);

        // Two speculative pushes
        cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, '0, 1'b0);
        check("push2_rd_addr", 32'(ram_bus.ram_addr0_o), 32'd1);
        check("push2_pred", 32'(pred_addr_o), 32'h22);
        check("push2_valid", 32'(pred_valid_o), 32'd1);
        idle();

        // Overflow wrap then full drain and underflow
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b0, '0, 1'b0);
        check("ovf_rd_addr", 32'(ram_bus.ram_addr0_o), 32'd0);
        check("ovf_pred", 32'(pred_addr_o), 32'h40);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
        check("drain15_valid", 32'(pred_valid_o), 32'd1);
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
        check("drain16_valid", 32'(pred_valid_o), 32'd0);
        check("drain16_rd_addr", 32'(ram_bus.ram_addr0_o), 32'd0);
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
        check("unf_valid", 32'(pred_valid_o), 32'd0);
        check("unf_rd_addr", 32'(ram_bus.ram_addr0_o), 32'd0);

        // Push+pop replaces top at specTos=3
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, '0, 1'b0);
        check("pre_repl_rd_addr", 32'(ram_bus.ram_addr0_o), 32'd3);
        cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, '0, 1'b0);
        check("repl_rd_addr", 32'(ram_bus.ram_addr0_o), 32'd3);
        check("repl_pred", 32'(pred_addr_o), 32'h77);
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
        check("repl_pop_pred", 32'(pred_addr_o), 32'h03);

        // Recovery restores spec state and RAM from architectural checkpoint
        do_reset();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'hA0, 1'b0);
        cycle(1'b1, 1'b0, 8'hB0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, '0, 1'b1);
        check("rec_ram_recover", 32'(ram_bus.ram_recover_o), 32'd1);
        check("rec_arch_ready", 32'(arch_ready_o), 32'd0);
        idle(1'b1);
        check("post_rec_rd_addr", 32'(ram_bus.ram_addr0_o), 32'd0);
        check("post_rec_pred", 32'(pred_addr_o), 32'hA0);
        check("post_rec_ram_recover", 32'(ram_bus.ram_recover_o), 32'd0);

        // Recover with simultaneous arch push
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h55, 1'b1);
        idle();
        check("rec_push_pred", 32'(pred_addr_o), 32'h55);
        check("rec_push_rd_addr", 32'(ram_bus.ram_addr0_o), 32'd1);
        idle();

        // Reset during RESTORE aborts it
        idle(1'b1);
        idle(1'b0, 1'b0);
        check("rst_restore_ram_recover", 32'(ram_bus.ram_recover_o), 32'd0);
        check("rst_restore_rd_addr", 32'(ram_bus.ram_addr0_o), 32'd15);
        check("rst_restore_valid", 32'(pred_valid_o), 32'd0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h66, 1'b0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
